// File: rtl/pwm_duty_meter_pkg.sv
// Shared types and constants for the PWM duty meter and its pin-capture helpers.
package pwm_duty_meter_pkg;

    // Default counter width; the longest measurable period is 2^CNT_W-1 cycles.
    localparam int unsigned CntWDefault       = 16;
    // Default synchronizer depth on the asynchronous PWM pin.
    localparam int unsigned SyncStagesDefault = 2;
    // Saturation value of the default-width counter; doubles as the timeout mark.
    localparam logic [CntWDefault-1:0] CtrAllOnesDefault = '1;

    // StIdle: no reference rising edge yet. StMeasure: counting since the last rise.
    typedef enum logic {
        StIdle    = 1'b0,
        StMeasure = 1'b1
    } meas_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes an asynchronous pin and flags its rising/falling edges.
module pwm_edge_sync
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic clk,
    input  logic reset_,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d_q;

    // Shift the pin through the synchronizer and keep a one-cycle delayed copy.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge strobes are one cycle wide and aligned to the synchronized level.
    always_comb begin
        pwm_s = sync_q[SYNC_STAGES-1];
        rise  = pwm_s & ~pwm_d_q;
        fall  = ~pwm_s & pwm_d_q;
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of a PWM waveform in clk cycles, with timeout detection.
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             stuck_o,
    output logic             level_o
);

    localparam logic [CNT_W-1:0] CtrAllOnes = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CtrOne     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic pwm_s;
    logic rise;
    logic fall;

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0] high_lat_q, high_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic [CNT_W-1:0] ctr_inc;
    logic             timeout;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .reset_ (reset_),
        .pwm_in (pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise),
        .fall   (fall)
    );

    // State, counter and published results.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q    <= StIdle;
            ctr_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            high_lat_q <= high_lat_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    // Next-state: arm on first rise, publish on later rises, time out on a static line.
    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        high_lat_d = high_lat_q;
        period_d   = period_q;
        high_d     = high_q;
        stuck_d    = stuck_q;
        valid_d    = 1'b0;
        ctr_inc    = (ctr_q == CtrAllOnes) ? ctr_q : ctr_q + CtrOne;
        // A rise in the same cycle as saturation wins and yields a normal result.
        timeout    = (ctr_q == CtrAllOnes) && !rise;

        if (!en) begin
            state_d    = StIdle;
            ctr_d      = '0;
            high_lat_d = '0;
        end else begin
            ctr_d = ctr_inc;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StMeasure;
                        ctr_d   = CtrOne;
                    end
                end
                StMeasure: begin
                    if (fall) begin
                        high_lat_d = ctr_q;
                    end
                    if (rise) begin
                        period_d = ctr_q;
                        high_d   = high_lat_q;
                        stuck_d  = 1'b0;
                        valid_d  = 1'b1;
                        ctr_d    = CtrOne;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (timeout) begin
                period_d = CtrAllOnes;
                high_d   = pwm_s ? CtrAllOnes : '0;
                stuck_d  = 1'b1;
                valid_d  = 1'b1;
                ctr_d    = CtrOne;
                state_d  = StIdle;
            end
        end
    end

    // Outputs come straight from registers except the synchronized level.
    always_comb begin
        period_o = period_q;
        high_o   = high_q;
        valid_o  = valid_q;
        stuck_o  = stuck_q;
        level_o  = pwm_s;
    end

endmodule
